// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: CE prescaler, per-button SHORT/LONG/REPEAT classifier
// and round-robin valid/ready event arbiter for a bank of debounce filters.
module btn_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int IDX_W        = 2,
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  output logic             CE_OUT,
  input  logic [N_BTN-1:0] BTN_LVL,
  input  logic [N_BTN-1:0] BTN_PRESS,
  output logic             EVT_VALID,
  input  logic             EVT_READY,
  output logic [IDX_W-1:0] EVT_IDX,
  output logic [1:0]       EVT_TYPE,
  output logic             OVF
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_HELD    = 2'd2;

  localparam logic [1:0] T_SHORT  = 2'b01;
  localparam logic [1:0] T_LONG   = 2'b10;
  localparam logic [1:0] T_REPEAT = 2'b11;

  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_BTN - 1);

  logic [PS_W-1:0] ps_q;
  logic            tick;

  assign tick   = EN && (ps_q == PS_LAST);
  assign CE_OUT = tick;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ps_q <= '0;
    end else if (EN) begin
      ps_q <= tick ? '0 : ps_q + 1'b1;
    end
  end

  logic [1:0]       st_q  [N_BTN];
  logic [1:0]       st_d  [N_BTN];
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] post;
  logic [1:0]       post_type [N_BTN];

  // Release is tested before the tick so it always wins
  always_comb begin
    post = '0;
    for (int i = 0; i < N_BTN; i++) begin
      st_d[i]      = st_q[i];
      cnt_d[i]     = cnt_q[i];
      post_type[i] = T_SHORT;
      if (!EN) begin
        st_d[i]  = S_IDLE;
        cnt_d[i] = '0;
      end else begin
        unique case (st_q[i])
          S_IDLE: begin
            if (BTN_PRESS[i]) begin
              st_d[i]  = S_PRESSED;
              cnt_d[i] = '0;
            end
          end
          S_PRESSED: begin
            if (!BTN_LVL[i]) begin
              post[i]      = 1'b1;
              post_type[i] = T_SHORT;
              st_d[i]      = S_IDLE;
            end else if (tick) begin
              if (cnt_q[i] == LONG_LAST) begin
                post[i]      = 1'b1;
                post_type[i] = T_LONG;
                st_d[i]      = S_HELD;
                cnt_d[i]     = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
          end
          S_HELD: begin
            if (!BTN_LVL[i]) begin
              st_d[i] = S_IDLE;
            end else if (tick) begin
              if (cnt_q[i] == REP_LAST) begin
                post[i]      = 1'b1;
                post_type[i] = T_REPEAT;
                cnt_d[i]     = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
          end
          default: begin
            st_d[i]  = S_IDLE;
            cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  logic [N_BTN-1:0] pend_q;
  logic [1:0]       ptype_q [N_BTN];
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] gidx;
  logic             gfound;
  logic             load;
  logic [N_BTN-1:0] gnt;

  // Rotated priority search: outer loop is distance from the pointer
  always_comb begin
    gfound = 1'b0;
    gidx   = '0;
    for (int j = 0; j < N_BTN; j++) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!gfound && ptr_q == IDX_W'(i) && pend_q[(i + j) % N_BTN]) begin
          gfound = 1'b1;
          gidx   = IDX_W'((i + j) % N_BTN);
        end
      end
    end
  end

  assign load = !EVT_VALID || EVT_READY;

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      gnt[i] = load && gfound && (gidx == IDX_W'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_BTN; i++) begin
        st_q[i]    <= S_IDLE;
        cnt_q[i]   <= '0;
        ptype_q[i] <= 2'b00;
      end
      pend_q    <= '0;
      ptr_q     <= '0;
      EVT_VALID <= 1'b0;
      EVT_IDX   <= '0;
      EVT_TYPE  <= 2'b00;
      OVF       <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        if (post[i] && pend_q[i] && !gnt[i]) begin
          OVF <= 1'b1;
        end else if (post[i]) begin
          pend_q[i]  <= 1'b1;
          ptype_q[i] <= post_type[i];
        end else if (gnt[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
      if (load) begin
        EVT_VALID <= gfound;
        if (gfound) begin
          EVT_IDX  <= gidx;
          EVT_TYPE <= ptype_q[gidx];
          ptr_q    <= (gidx == IDX_LAST) ? '0 : gidx + 1'b1;
        end
      end
    end
  end

endmodule
